// File: rtl/glyph_pixel_reader.sv
// Purpose: fetch an 8x8 glyph from the font ROM and stream it as 64 RGB565 pixels, row-major.
// Latency: first pixel 3 cycles after the accepting edge; 10 cycles per row when unstalled.
// Backpressure: pix_valid/pix_data/pix_last hold until pix_ready; char_ready only in IDLE.
module glyph_pixel_reader #(
    parameter logic [7:0] FIRST_CHAR = 8'h20,
    parameter int         NUM_CHARS  = 96,      // must be <= 128: glyph index is 7 bits
    parameter logic [7:0] SUB_CHAR   = 8'h3F,
    parameter bit         MSB_LEFT   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_code,
    input  logic [15:0] fg,
    input  logic [15:0] bg,
    output logic [9:0]  font_ad,
    output logic        font_ce,
    output logic        font_oce,
    input  logic [7:0]  font_dout,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        pix_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAP  = 2'd2,
        PIX  = 2'd3
    } state_t;

    // 9-bit bounds so FIRST_CHAR+NUM_CHARS cannot wrap past 8'hFF.
    localparam logic [8:0] CODE_LO = {1'b0, FIRST_CHAR};
    localparam logic [8:0] CODE_HI = CODE_LO + 9'(NUM_CHARS);
    localparam logic [6:0] SUB_IDX = 7'(SUB_CHAR - FIRST_CHAR);

    state_t      state;
    logic [6:0]  idx_q;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [7:0]  row_bits;
    logic [15:0] fg_q;
    logic [15:0] bg_q;

    logic [8:0]  code_ext;
    logic        code_in_range;
    logic [6:0]  idx_next;

    // Bit of the shift register that is the current (leftmost remaining) pixel.
    function automatic logic lead_bit(input logic [7:0] b);
        lead_bit = MSB_LEFT ? b[7] : b[0];
    endfunction

    // Move the next pixel of the row into the lead position.
    function automatic logic [7:0] advance(input logic [7:0] b);
        advance = MSB_LEFT ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    // Map the incoming code to a glyph index; out-of-range codes render SUB_CHAR.
    always_comb begin
        code_ext      = {1'b0, char_code};
        code_in_range = (code_ext >= CODE_LO) && (code_ext < CODE_HI);
        idx_next      = code_in_range ? 7'(char_code - FIRST_CHAR) : SUB_IDX;
    end

    // Main FSM: one ROM read per row, then eight pixel beats from the captured row byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx_q     <= '0;
            row       <= '0;
            col       <= '0;
            row_bits  <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            font_ad   <= '0;
            font_ce   <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // char_ready is high whenever IDLE is held out of reset.
                    if (char_valid) begin
                        idx_q   <= idx_next;
                        fg_q    <= fg;
                        bg_q    <= bg;
                        row     <= 3'd0;
                        col     <= 3'd0;
                        font_ad <= {idx_next, 3'd0};
                        font_ce <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    font_ce <= 1'b0;
                    state   <= CAP;
                end
                CAP: begin
                    // font_dout now holds the row byte addressed during ADDR.
                    row_bits  <= font_dout;
                    col       <= 3'd0;
                    pix_data  <= lead_bit(font_dout) ? fg_q : bg_q;
                    pix_last  <= 1'b0;
                    pix_valid <= 1'b1;
                    state     <= PIX;
                end
                PIX: begin
                    if (pix_ready) begin
                        if (col == 3'd7) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            if (row == 3'd7) begin
                                state <= IDLE;
                            end else begin
                                row     <= row + 3'd1;
                                font_ad <= {idx_q, row + 3'd1};
                                font_ce <= 1'b1;
                                state   <= ADDR;
                            end
                        end else begin
                            col      <= col + 3'd1;
                            row_bits <= advance(row_bits);
                            pix_data <= lead_bit(advance(row_bits)) ? fg_q : bg_q;
                            pix_last <= (row == 3'd7) && (col == 3'd6);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so it reads 0 for the whole reset period.
    assign char_ready = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);
    assign font_oce   = 1'b1;

endmodule
